// File: rtl/temporizador_pkg.sv
`default_nettype none
// ============================================================================
// Module   : temporizador_pkg
// Purpose  : Shared state encoding and default width for the down-counter.
// Revision : 1.0 - initial release
// ============================================================================
package temporizador_pkg;

  localparam int TEMP_N = 4;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage : temporizador_pkg
`default_nettype wire

// File: rtl/temporizador_decrescente.sv
`default_nettype none
// ============================================================================
// Module   : temporizador_decrescente
// Purpose  : Cascadable N-bit down-counter with terminal-count pulse, optional
//            auto-reload and 74163-style borrow output.
// Revision : 1.0 - initial release
// ============================================================================
module temporizador_decrescente
  import temporizador_pkg::*;
#(
  parameter int N = TEMP_N
) (
  input  logic         CLK,
  input  logic         CLR,
  input  logic         LD,
  input  logic         ENP,
  input  logic         ENT,
  input  logic         RELOAD,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         BO,
  output logic         FIM,
  output logic         ATIVO
);

  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_q, w_q_nxt;
  logic [N-1:0] r_r, w_r_nxt;
  logic         r_fim, w_fim_nxt;
  logic         w_count;

  assign w_count = ENP && ENT;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_r     <= '0;
      r_fim   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_r     <= w_r_nxt;
      r_fim   <= w_fim_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_r_nxt     = r_r;
    w_fim_nxt   = 1'b0;

    if (!LD) begin
      w_q_nxt     = D;
      w_r_nxt     = D;
      w_state_nxt = (D != '0) ? S_RUN : S_IDLE;
    end else if (w_count && (r_state == S_RUN)) begin
      if (r_q > N'(1)) begin
        w_q_nxt = r_q - N'(1);
      end else if (r_q == N'(1)) begin
        // Terminal count: RELOAD is only looked at on this edge.
        w_fim_nxt = 1'b1;
        if (RELOAD) begin
          w_q_nxt = r_r;
        end else begin
          w_q_nxt     = '0;
          w_state_nxt = S_IDLE;
        end
      end else begin
        // Zero while running is unreachable; fall back to a safe stop.
        w_state_nxt = S_IDLE;
      end
    end
  end

  assign Q     = r_q;
  assign FIM   = r_fim;
  assign ATIVO = (r_state == S_RUN);
  assign BO    = ENT && (r_q == '0);

endmodule : temporizador_decrescente
`default_nettype wire

// File: tb/tb_temporizador_decrescente.sv
`default_nettype none
// ============================================================================
// Module   : tb_temporizador_decrescente
// Purpose  : Self-checking bench: vector table with scoreboard plus
//            hand-written reset and cascade sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_temporizador_decrescente;
  import temporizador_pkg::*;

  localparam int W = TEMP_N;

  logic         CLK = 1'b0;
  logic         CLR, LD, ENP, ENT, RELOAD;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         BO, FIM, ATIVO;

  // cascade pair
  logic         lo_ld, hi_ld, c_enp;
  logic [W-1:0] lo_d, hi_d;
  logic [W-1:0] lo_q, hi_q;
  logic         lo_bo, hi_bo, lo_fim, hi_fim, lo_ativo, hi_ativo;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  temporizador_decrescente #(.N(W)) dut (
    .CLK(CLK), .CLR(CLR), .LD(LD), .ENP(ENP), .ENT(ENT), .RELOAD(RELOAD),
    .D(D), .Q(Q), .BO(BO), .FIM(FIM), .ATIVO(ATIVO)
  );

  temporizador_decrescente #(.N(W)) u_lo (
    .CLK(CLK), .CLR(CLR), .LD(lo_ld), .ENP(c_enp), .ENT(1'b1), .RELOAD(1'b1),
    .D(lo_d), .Q(lo_q), .BO(lo_bo), .FIM(lo_fim), .ATIVO(lo_ativo)
  );

  temporizador_decrescente #(.N(W)) u_hi (
    .CLK(CLK), .CLR(CLR), .LD(hi_ld), .ENP(c_enp), .ENT(lo_bo), .RELOAD(1'b1),
    .D(hi_d), .Q(hi_q), .BO(hi_bo), .FIM(hi_fim), .ATIVO(hi_ativo)
  );

  typedef struct {
    logic         ld;
    logic [W-1:0] d;
    logic         enp;
    logic         ent;
    logic         rl;
    logic [W-1:0] q;
    logic         fim;
    logic         ativo;
    logic         bo;
    string        name;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic         fim;
    logic         ativo;
    logic         bo;
    string        name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic void add(input logic ld, input int d, input logic enp, input logic ent,
                              input logic rl, input int q, input logic fim, input logic ativo,
                              input logic bo, input string name);
    vec_t v;
    v.ld = ld; v.d = W'(d); v.enp = enp; v.ent = ent; v.rl = rl;
    v.q = W'(q); v.fim = fim; v.ativo = ativo; v.bo = bo; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    exp_t e;

    // ld d enp ent rl | q fim ativo bo
    add(1,  0, 1, 1, 0,  0, 0, 0, 1, "idle_nowrap");
    add(0,  3, 1, 1, 0,  3, 0, 1, 0, "os_load");
    add(1,  0, 1, 1, 0,  2, 0, 1, 0, "os_2");
    add(1,  0, 1, 1, 0,  1, 0, 1, 0, "os_1");
    add(1,  0, 1, 1, 0,  0, 1, 0, 1, "os_tc");
    for (int i = 0; i < 5; i++)
      add(1, 0, 1, 1, 0, 0, 0, 0, 1, "os_hold");
    add(0,  2, 1, 1, 1,  2, 0, 1, 0, "ar_load");
    add(1,  0, 1, 1, 1,  1, 0, 1, 0, "ar_1a");
    add(1,  0, 1, 1, 1,  2, 1, 1, 0, "ar_tc_a");
    add(1,  0, 1, 1, 1,  1, 0, 1, 0, "ar_1b");
    add(1,  0, 1, 1, 1,  2, 1, 1, 0, "ar_tc_b");
    add(0,  5, 1, 1, 0,  5, 0, 1, 0, "gate_load");
    add(1,  0, 1, 1, 0,  4, 0, 1, 0, "gate_c1");
    add(1,  0, 0, 1, 0,  4, 0, 1, 0, "gate_enp0");
    add(1,  0, 1, 0, 0,  4, 0, 1, 0, "gate_ent0");
    add(1,  0, 0, 0, 0,  4, 0, 1, 0, "gate_both0");
    add(1,  0, 1, 1, 0,  3, 0, 1, 0, "gate_c2");
    add(1,  0, 0, 1, 0,  3, 0, 1, 0, "gate_enp0b");
    add(1,  0, 1, 0, 0,  3, 0, 1, 0, "gate_ent0b");
    add(1,  0, 1, 1, 0,  2, 0, 1, 0, "gate_c3");
    add(0,  2, 1, 1, 0,  2, 0, 1, 0, "pri_load2");
    add(1,  0, 1, 1, 0,  1, 0, 1, 0, "pri_at1");
    add(0,  7, 1, 1, 0,  7, 0, 1, 0, "pri_ld_over_tc");
    add(0,  0, 1, 1, 0,  0, 0, 0, 1, "pri_load0");
    add(1,  0, 1, 0, 0,  0, 0, 0, 0, "pri_bo_ent0");
    add(0, 15, 1, 1, 0, 15, 0, 1, 0, "max_load");
    add(1,  0, 1, 1, 0, 14, 0, 1, 0, "max_dec");
    add(0,  1, 1, 1, 1,  1, 0, 1, 0, "r1_load");
    add(1,  0, 1, 1, 1,  1, 1, 1, 0, "r1_tc_a");
    add(1,  0, 1, 1, 1,  1, 1, 1, 0, "r1_tc_b");
    add(0,  2, 1, 1, 1,  2, 0, 1, 0, "rlchg_load");
    add(1,  0, 1, 1, 0,  1, 0, 1, 0, "rlchg_1");
    add(1,  0, 1, 1, 0,  0, 1, 0, 1, "rlchg_tc");

    CLR = 1'b1; LD = 1'b1; ENP = 1'b0; ENT = 1'b1; RELOAD = 1'b0; D = '0;
    lo_ld = 1'b1; hi_ld = 1'b1; lo_d = '0; hi_d = '0; c_enp = 1'b0;

    #1;
    check("rst.q", 32'(Q), 0);
    check("rst.fim", 32'(FIM), 0);
    check("rst.ativo", 32'(ATIVO), 0);
    check("rst.bo", 32'(BO), 1);
    tick();
    CLR = 1'b0;

    // Async clear mid-count, checked before the next edge
    LD = 1'b0; D = W'(9); ENP = 1'b1; ENT = 1'b1;
    tick();
    LD = 1'b1;
    repeat (3) tick();
    check("clr_pre.q", 32'(Q), 6);
    check("clr_pre.ativo", 32'(ATIVO), 1);
    #2 CLR = 1'b1;
    #1;
    check("clr_mid.q", 32'(Q), 0);
    check("clr_mid.ativo", 32'(ATIVO), 0);
    tick();
    CLR = 1'b0;

    // Clear while FIM is high must drop it immediately
    LD = 1'b0; D = W'(1);
    tick();
    LD = 1'b1;
    tick();
    check("clr_fim_pre", 32'(FIM), 1);
    #2 CLR = 1'b1;
    #1;
    check("clr_fim_mid", 32'(FIM), 0);
    check("clr_fim_q", 32'(Q), 0);
    tick();
    CLR = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      LD = vecs[i].ld; D = vecs[i].d; ENP = vecs[i].enp; ENT = vecs[i].ent; RELOAD = vecs[i].rl;
      e.q = vecs[i].q; e.fim = vecs[i].fim; e.ativo = vecs[i].ativo; e.bo = vecs[i].bo;
      e.name = $sformatf("%s[%0d]", vecs[i].name, i);
      sb.push_back(e);
      tick();
      if (sb.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL scoreboard_empty at vector %0d", i);
      end else begin
        e = sb.pop_front();
        check({e.name, ".q"}, 32'(Q), 32'(e.q));
        check({e.name, ".fim"}, 32'(FIM), 32'(e.fim));
        check({e.name, ".ativo"}, 32'(ATIVO), 32'(e.ativo));
        check({e.name, ".bo"}, 32'(BO), 32'(e.bo));
      end
    end
    LD = 1'b1; ENP = 1'b0;

    // Cascade: high stage steps only on the edge where the low borrow is high
    lo_ld = 1'b0; lo_d = '0; hi_ld = 1'b0; hi_d = W'(2); c_enp = 1'b0;
    tick();
    lo_ld = 1'b1; hi_ld = 1'b1;
    check("cas_init.hi_q", 32'(hi_q), 2);
    check("cas_init.lo_bo", 32'(lo_bo), 1);
    c_enp = 1'b1;
    tick();
    check("cas_step.hi_q", 32'(hi_q), 1);
    check("cas_step.hi_fim", 32'(hi_fim), 0);
    c_enp = 1'b0; lo_ld = 1'b0; lo_d = W'(15);
    tick();
    lo_ld = 1'b1; c_enp = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      check($sformatf("cas_run[%0d].hi_q", k), 32'(hi_q), 1);
      check($sformatf("cas_run[%0d].lo_bo", k), 32'(lo_bo), 0);
    end
    check("cas_end.lo_q", 32'(lo_q), 15);
    c_enp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_temporizador_decrescente
`default_nettype wire
